// File: rtl/approx_pkg.sv
// Shared types and helpers for the folded approximate multiplier.
package approx_pkg;

    // Sequencer states: waiting for operands, folding partial products, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Which of the four half-width partial products is being accumulated.
    typedef logic [1:0] phase_t;

    // Left shift applied to the core product in a given phase, for operand width n.
    // Phase 0 is low*low, phases 1 and 2 are the cross terms, phase 3 is high*high.
    function automatic int phase_shift(input int n, input phase_t phase);
        int shift;
        shift = 0;
        case (phase)
            2'd0:       shift = 0;
            2'd1, 2'd2: shift = n / 2;
            default:    shift = n;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/ApproxMult.sv
// Recursive approximate multiplier: an n x n product is built from four
// n/2 x n/2 products; the 2x2 leaf returns 7 instead of 9 for 3*3 so that
// every leaf result fits in three bits.
module ApproxMult #(
    parameter int n = 4
) (
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic [2*n-1:0] p
);

    if (n == 2) begin : g_leaf
        // The 2x2 leaf drops the carry out of bit 1, which is where 3*3 becomes 7.
        assign p = {1'b0, a[1] & b[1], (a[1] & b[0]) | (a[0] & b[1]), a[0] & b[0]};
    end else begin : g_split
        localparam int H = n / 2;

        logic [n-1:0] p_ll;
        logic [n-1:0] p_hl;
        logic [n-1:0] p_lh;
        logic [n-1:0] p_hh;

        ApproxMult #(.n(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(p_ll));
        ApproxMult #(.n(H)) u_hl (.a(a[n-1:H]), .b(b[H-1:0]), .p(p_hl));
        ApproxMult #(.n(H)) u_lh (.a(a[H-1:0]), .b(b[n-1:H]), .p(p_lh));
        ApproxMult #(.n(H)) u_hh (.a(a[n-1:H]), .b(b[n-1:H]), .p(p_hh));

        // Recombine the four partial products at their binary weights.
        assign p = {{n{1'b0}}, p_ll}
                 + {{H{1'b0}}, p_hl, {H{1'b0}}}
                 + {{H{1'b0}}, p_lh, {H{1'b0}}}
                 + {p_hh, {n{1'b0}}};
    end

endmodule

// File: rtl/approx_mult_seq.sv
// Folded approximate multiplier: one half-width ApproxMult core is reused over
// four cycles, giving the same product as a full-width combinational ApproxMult.
// N must be a power of two and at least 4 so the core is at least 2 bits wide.
module approx_mult_seq
    import approx_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result
);

    localparam int H = N / 2;

    state_t         state_q;
    state_t         state_d;
    phase_t         phase_q;
    phase_t         phase_d;
    logic [N-1:0]   a_q;
    logic [N-1:0]   a_d;
    logic [N-1:0]   b_q;
    logic [N-1:0]   b_d;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] acc_d;

    logic [H-1:0]   core_a;
    logic [H-1:0]   core_b;
    logic [N-1:0]   core_p;
    logic [2*N-1:0] core_shifted;

    // Pick the operand halves for this phase: bit 0 selects A's half, bit 1 selects B's.
    always_comb begin
        core_a = phase_q[0] ? a_q[N-1:H] : a_q[H-1:0];
        core_b = phase_q[1] ? b_q[N-1:H] : b_q[H-1:0];
    end

    ApproxMult #(.n(H)) u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    assign core_shifted = {{N{1'b0}}, core_p} << phase_shift(N, phase_q);

    // Handshake flags come only from registered state; in_ready is also held low during reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = acc_q;

    // Next-state logic: accept in IDLE, fold one partial product per CALC cycle, wait for the consumer in DONE.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    phase_d = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_q + core_shifted;
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight and clears the pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Directed and randomised checks of approx_mult_seq at N=16 and N=4.
module tb_approx_mult_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] result16;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        out_valid4;
    logic        out_ready4;
    logic [7:0]  result4;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    approx_mult_seq #(.N(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .result    (result16)
    );

    approx_mult_seq #(.N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .result    (result4)
    );

    // Reference: the recursion flattens to a sum over all 2-bit digit pairs,
    // each multiplied with the 3*3 -> 7 leaf rule and placed at weight 4^(i+j).
    function automatic logic [63:0] approx_model(input logic [31:0] x, input logic [31:0] y, input int n);
        logic [63:0] sum;
        sum = 64'd0;
        for (int i = 0; i < n / 2; i++) begin
            for (int j = 0; j < n / 2; j++) begin
                int xd;
                int yd;
                int leaf;
                xd = int'((x >> (2 * i)) & 32'd3);
                yd = int'((y >> (2 * j)) & 32'd3);
                leaf = (xd == 3 && yd == 3) ? 7 : xd * yd;
                sum = sum + (64'(leaf) << (2 * (i + j)));
            end
        end
        return sum;
    endfunction

    // One full transaction on the 16-bit instance, checking latency, result and handoff.
    task automatic run_op16(input logic [15:0] op_a, input logic [15:0] op_b,
                            input logic [31:0] expected, input string name);
        int guard;
        int lat;
        guard = 0;
        while (in_ready16 !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        assert_count++;
        if (in_ready16 !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL %s_ready: in_ready=%0b expected 1", name, in_ready16);
        end
        in_valid16 = 1'b1;
        a16 = op_a;
        b16 = op_b;
        @(negedge clk);
        in_valid16 = 1'b0;
        a16 = ~op_a;
        b16 = ~op_b;
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        assert_count++;
        if (lat !== 4) begin
            fail_count++;
            $display("[TB] FAIL %s_latency: got %0d cycles expected 4", name, lat);
        end
        assert_count++;
        if (result16 !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s_result: got %0d expected %0d", name, result16, expected);
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        assert_count++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL %s_handoff: out_valid=%0b in_ready=%0b expected 0/1",
                     name, out_valid16, in_ready16);
        end
        assert_count++;
        if (result16 !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s_hold_idle: got %0d expected %0d", name, result16, expected);
        end
    endtask

    // One full transaction on the 4-bit instance.
    task automatic run_op4(input logic [3:0] op_a, input logic [3:0] op_b,
                           input logic [7:0] expected, input string name);
        int lat;
        in_valid4 = 1'b1;
        a4 = op_a;
        b4 = op_b;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        assert_count++;
        if (lat !== 4 || result4 !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: result=%0d latency=%0d expected %0d after 4",
                     name, result4, lat, expected);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    // Outputs while reset is held, then readiness after release.
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        assert_count++;
        if (result16 !== 32'd0 || out_valid16 !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_outputs: result=%0d out_valid=%0b expected 0/0", result16, out_valid16);
        end
        assert_count++;
        if (in_ready16 !== 1'b0 || in_ready4 !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_in_ready: in_ready16=%0b in_ready4=%0b expected 0/0", in_ready16, in_ready4);
        end
        rst = 1'b0;
        @(negedge clk);
        assert_count++;
        if (in_ready16 !== 1'b1 || in_ready4 !== 1'b1 || out_valid16 !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL post_reset: in_ready16=%0b in_ready4=%0b out_valid16=%0b expected 1/1/0",
                     in_ready16, in_ready4, out_valid16);
        end
    endtask

    // Small and exact-case products on the 16-bit instance.
    task automatic test_basic();
        run_op16(16'd3,     16'd3,     32'd7,     "mul_3x3");
        run_op16(16'd2,     16'd3,     32'd6,     "mul_2x3");
        run_op16(16'h0100,  16'h0100,  32'd65536, "mul_256x256");
    endtask

    // All-ones operands, where the approximation error is largest.
    task automatic test_max();
        run_op16(16'hFFFF, 16'hFFFF, 32'd3340428175, "mul_ffff");
        run_op4(4'hF, 4'hF, 8'd175, "n4_mul_f");
        run_op4(4'h3, 4'h3, 8'd7,   "n4_mul_3x3");
        run_op4(4'h6, 4'h5, 8'd30,  "n4_mul_6x5");
    endtask

    // Consumer stalls for 10 cycles in DONE; everything must hold still.
    task automatic test_backpressure();
        int guard;
        in_valid16 = 1'b1;
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        @(negedge clk);
        in_valid16 = 1'b0;
        guard = 0;
        while (out_valid16 !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            assert_count++;
            if (out_valid16 !== 1'b1 || result16 !== 32'd3340428175 || in_ready16 !== 1'b0) begin
                fail_count++;
                $display("[TB] FAIL backpressure_%0d: out_valid=%0b result=%0d in_ready=%0b expected 1/3340428175/0",
                         i, out_valid16, result16, in_ready16);
            end
            @(negedge clk);
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    // New operands with toggling in_valid during CALC and DONE must not disturb the product.
    task automatic test_ignore_in_valid();
        int guard;
        in_valid16 = 1'b1;
        a16 = 16'd2;
        b16 = 16'd3;
        @(negedge clk);
        guard = 0;
        while (out_valid16 !== 1'b1 && guard < 20) begin
            in_valid16 = ~in_valid16;
            a16 = a16 + 16'h1111;
            b16 = 16'hFFFF;
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid16 = ~in_valid16;
            a16 = 16'hABCD;
            @(negedge clk);
        end
        in_valid16 = 1'b0;
        assert_count++;
        if (result16 !== 32'd6 || out_valid16 !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL ignore_in_valid: result=%0d out_valid=%0b expected 6/1", result16, out_valid16);
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    // Reset during phase 2 aborts asynchronously; the next operation starts clean.
    task automatic test_reset_mid_calc();
        in_valid16 = 1'b1;
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        assert_count++;
        if (out_valid16 !== 1'b0 || result16 !== 32'd0 || in_ready16 !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_mid_calc: out_valid=%0b result=%0d in_ready=%0b expected 0/0/0",
                     out_valid16, result16, in_ready16);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        assert_count++;
        if (in_ready16 !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL ready_after_abort: in_ready=%0b expected 1", in_ready16);
        end
        run_op16(16'd5, 16'd7, 32'd35, "mul_5x7_after_abort");
    endtask

    // Random operands with random producer gaps and consumer stalls, checked against the digit model.
    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic [31:0] expected;
            int guard;
            bit taken;
            ra = 16'($urandom);
            rb = 16'($urandom);
            expected = 32'(approx_model({16'd0, ra}, {16'd0, rb}, 16));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            guard = 0;
            while (in_ready16 !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            in_valid16 = 1'b1;
            a16 = ra;
            b16 = rb;
            @(negedge clk);
            in_valid16 = 1'b0;
            taken = 1'b0;
            guard = 0;
            while (!taken && guard < 60) begin
                out_ready16 = 1'($urandom_range(0, 1));
                if (out_valid16 === 1'b1 && out_ready16 === 1'b1) begin
                    taken = 1'b1;
                    assert_count++;
                    if (result16 !== expected) begin
                        fail_count++;
                        $display("[TB] FAIL random_%0d: a=%0h b=%0h got %0d expected %0d",
                                 n, ra, rb, result16, expected);
                    end
                end
                @(negedge clk);
                guard++;
            end
            out_ready16 = 1'b0;
            if (!taken) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL random_timeout_%0d: no result within 60 cycles", n);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;
        a16         = 16'd0;
        b16         = 16'd0;
        in_valid4   = 1'b0;
        out_ready4  = 1'b0;
        a4          = 4'd0;
        b4          = 4'd0;
        #2;
        rst = 1'b1;
        $display("[TB] starting approx_mult_seq checks");
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_calc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
